// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// It detects load-use hazards, inserts bubbles and keeps a saturating stall counter.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                id_reg_dst,
    input  logic [1:0]                id_mem_to_reg,
    input  logic                      id_reg_write,
    input  logic                      id_alu_src,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic [2:0]                id_operation,
    input  logic [DATA_WIDTH-1:0]     id_read_data1,
    input  logic [DATA_WIDTH-1:0]     id_read_data2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      ex_flush,
    output logic [1:0]                ex_reg_dst,
    output logic [1:0]                ex_mem_to_reg,
    output logic                      ex_reg_write,
    output logic                      ex_alu_src,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic [2:0]                ex_operation,
    output logic [DATA_WIDTH-1:0]     ex_read_data1,
    output logic [DATA_WIDTH-1:0]     ex_read_data2,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    logic hazard;
    logic bubble;

    // id_rt is compared for every format; a spurious stall is cheaper than a missed one.
    assign hazard = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign bubble      = ex_flush || hazard;
    assign pc_write    = ~hazard;
    assign if_id_write = ~hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg_dst    <= '0;
            ex_mem_to_reg <= '0;
            ex_reg_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_operation  <= '0;
        end else if (bubble) begin
            ex_reg_dst    <= '0;
            ex_mem_to_reg <= '0;
            ex_reg_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_operation  <= '0;
        end else begin
            ex_reg_dst    <= id_reg_dst;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_reg_write  <= id_reg_write;
            ex_alu_src    <= id_alu_src;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_operation  <= id_operation;
        end
    end

    // Operands load even in a bubble so the EX contents stay deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_pc_plus4   <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
        end else begin
            ex_read_data1 <= id_read_data1;
            ex_read_data2 <= id_read_data2;
            ex_imm        <= id_imm;
            ex_pc_plus4   <= id_pc_plus4;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule
